// File: rtl/barrel_shifter_pkg.sv
// Shared encodings for the barrel shifter: operation codes and shift directions.
package barrel_shifter_pkg;

  typedef enum logic [1:0] {
    OP_LOGICAL = 2'b00,
    OP_ARITH   = 2'b01,
    OP_ROTATE  = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shifter_stage.sv
// One fixed-distance conditional shift/rotate step of the logarithmic shifter.
module barrel_shifter_stage
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             dir,
  input  logic             fill_bit,
  input  logic             rotate,
  output logic [WIDTH-1:0] dout
);

  logic [DIST-1:0] lo_fill;
  logic [DIST-1:0] hi_fill;

  // Bits entering at the vacated end: wrapped bits on rotate, else zero/sign fill.
  assign lo_fill = rotate ? din[WIDTH-1 -: DIST] : '0;
  assign hi_fill = rotate ? din[DIST-1:0] : {DIST{fill_bit}};

  always_comb begin
    dout = din;
    if (en) begin
      if (dir == DIR_RIGHT) dout = {hi_fill, din[WIDTH-1:DIST]};
      else                  dout = {din[WIDTH-DIST-1:0], lo_fill};
    end
  end

endmodule

// File: rtl/barrel_shifter.sv
// 32-bit logarithmic barrel shifter (logical/arithmetic/rotate), one-cycle registered result.
module barrel_shifter
  import barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift_amt,
  input  logic             dir,
  input  logic [1:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out
);

  logic [SHW:0][WIDTH-1:0] stage_d;
  logic                    fill_bit;
  logic                    rotate;

  // Sign fill only matters for right shifts; left arithmetic equals logical left.
  assign fill_bit   = (op == OP_ARITH) & data_in[WIDTH-1];
  assign rotate     = (op == OP_ROTATE);
  assign stage_d[0] = data_in;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_shifter_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k)
    ) u_stage (
      .din      (stage_d[k]),
      .en       (shift_amt[k]),
      .dir      (dir),
      .fill_bit (fill_bit),
      .rotate   (rotate),
      .dout     (stage_d[k+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) data_out <= stage_d[SHW];
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench: directed vectors plus random ops against an arithmetic reference model.
module tb_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0]  shift_amt = '0;
  logic        dir = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        out_valid;
  logic [31:0] data_out;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] last_exp = '0;

  barrel_shifter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .shift_amt (shift_amt),
    .dir       (dir),
    .op        (op),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%08h exp=%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_f(input logic [31:0] d, input int s, input logic r, input logic [1:0] o);
    logic [31:0] res;
    if (o == 2'b10) begin
      if (s == 0) res = d;
      else if (r) res = (d >> s) | (d << (32 - s));
      else        res = (d << s) | (d >> (32 - s));
    end else if (o == 2'b01 && r) begin
      res = 32'($signed(d) >>> s);
    end else begin
      res = r ? (d >> s) : (d << s);
    end
    return res;
  endfunction

  // Drive one op, wait for the edge, check one cycle later; leaves in_valid high.
  task automatic do_op(input string tag, input logic [31:0] d, input int s, input logic r,
                       input logic [1:0] o, input logic [31:0] exp);
    in_valid  = 1'b1;
    data_in   = d;
    shift_amt = 5'(s);
    dir       = r;
    op        = o;
    @(posedge clk); #1;
    chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    chk(tag, data_out, exp);
    last_exp = exp;
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    data_in  = $urandom;
    @(posedge clk); #1;
    chk({tag, "_vld"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_hold"}, data_out, last_exp);
  endtask

  initial begin
    #2;
    chk("rst_vld", {31'b0, out_valid}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // logical left, back-to-back
    do_op("sll0", 32'h0000000F, 0, 1'b0, 2'b00, 32'h0000000F);
    do_op("sll1", 32'h0000000F, 1, 1'b0, 2'b00, 32'h0000001E);
    do_op("sll2", 32'h0000000F, 2, 1'b0, 2'b00, 32'h0000003C);
    do_op("sll5", 32'h0000000F, 5, 1'b0, 2'b00, 32'h000001E0);
    // logical right
    do_op("srl3", 32'h0000000F, 3, 1'b1, 2'b00, 32'h00000001);
    do_op("srl4", 32'h0000000F, 4, 1'b1, 2'b00, 32'h00000000);
    do_op("srl6", 32'h0000000F, 6, 1'b1, 2'b00, 32'h00000000);
    // arithmetic, rotate
    do_op("sra4", 32'h80000000, 4, 1'b1, 2'b01, 32'hF8000000);
    do_op("sra4p", 32'h70000000, 4, 1'b1, 2'b01, 32'h07000000);
    do_op("sla4", 32'h8000000F, 4, 1'b0, 2'b01, 32'h000000F0);
    do_op("rol4", 32'h8000000F, 4, 1'b0, 2'b10, 32'h000000F8);
    do_op("ror4", 32'h8000000F, 4, 1'b1, 2'b10, 32'hF8000000);
    do_op("ror0", 32'h8000000F, 0, 1'b1, 2'b10, 32'h8000000F);
    do_op("rsv3", 32'h8000000F, 4, 1'b1, 2'b11, 32'h08000000);
    // extremes
    do_op("sll31", 32'hFFFFFFFF, 31, 1'b0, 2'b00, 32'h80000000);
    do_op("srl31", 32'hFFFFFFFF, 31, 1'b1, 2'b00, 32'h00000001);
    do_op("sra31", 32'h80000000, 31, 1'b1, 2'b01, 32'hFFFFFFFF);
    idle("idle0");
    idle("idle1");

    // async reset mid-cycle with a result held and another in flight
    do_op("pre_rst", 32'h12345678, 8, 1'b0, 2'b10, 32'h34567812);
    data_in = 32'hDEADBEEF;
    #3 rst = 1'b1;
    #1;
    chk("arst_vld", {31'b0, out_valid}, 32'd0);
    chk("arst_data", data_out, 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_vld", {31'b0, out_valid}, 32'd0);
    chk("rst_hold_data", data_out, 32'd0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    last_exp = '0;
    idle("post_rst");
    do_op("post_rst_op", 32'h0000F000, 12, 1'b1, 2'b00, 32'h0000000F);

    // random ops with occasional bubbles
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] d;
      int          s;
      logic        r;
      logic [1:0]  o;
      d = $urandom;
      s = int'($urandom_range(31, 0));
      r = 1'($urandom);
      o = 2'($urandom);
      if ($urandom_range(15, 0) == 0) idle("rnd_idle");
      do_op("rnd", d, s, r, o, ref_f(d, s, r, o));
    end

    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
